// File: rtl/mem_dumper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dumper_pkg
//  Description : Shared types and constants for the memory dumper. It defines
//                the dump FSM state encoding, the word/byte geometry and a
//                helper that sizes the word counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_dumper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_LSB       = 2;

  // Word counter width. A depth of 1 still needs a 1-bit register.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_dumper_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : word_serializer
//  Description : Holds one 32-bit word and emits it as 4 bytes, least
//                significant byte first, on a valid/ready stream.
//  Ports       : clk_i, rst_i   - clock, synchronous active-high reset
//                load_i         - capture word_i and restart at byte 0
//                word_i[31:0]   - word to serialise
//                ready_i        - downstream accepts the byte this cycle
//                data_o[7:0]    - current byte (0 when no byte is held)
//                valid_o        - data_o holds a byte
//                last_o         - pulses with the accept of byte 3
//  Revision    : 1.0 - initial release
// ============================================================================
module word_serializer
  import mem_dumper_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        ready_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        last_o
);

  logic [31:0] r_word;
  logic [1:0]  r_byte_idx;
  logic        r_valid;

  logic        w_accept;
  logic        w_final_byte;

  assign w_accept     = r_valid & ready_i;
  assign w_final_byte = (r_byte_idx == 2'(BYTES_PER_WORD - 1));

  // The word is a snapshot taken at load time, so later writes to the
  // memory cannot change bytes that are still queued for transmission.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_word     <= 32'h0;
      r_byte_idx <= 2'd0;
      r_valid    <= 1'b0;
    end else if (load_i) begin
      r_word     <= word_i;
      r_byte_idx <= 2'd0;
      r_valid    <= 1'b1;
    end else if (w_accept) begin
      if (w_final_byte) begin
        r_valid    <= 1'b0;
        r_byte_idx <= 2'd0;
      end else begin
        r_byte_idx <= r_byte_idx + 2'd1;
      end
    end
  end

  // Valid and data come straight from registers; ready only advances them.
  assign valid_o = r_valid;
  assign data_o  = r_valid ? r_word[{r_byte_idx, 3'b000} +: 8] : 8'h00;
  assign last_o  = w_accept & w_final_byte;

endmodule
`default_nettype wire

// File: rtl/mem_dumper.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dumper
//  Description : Read-side master for the data memory snoop port. On a start
//                pulse it walks words 0..DEPTH-1 and streams each word as four
//                bytes (LSB first) towards the debug UART transmitter.
//  Ports       : clk_i, rst_i      - clock, synchronous active-high reset
//                start_i           - dump request, honoured only in IDLE
//                busy_o            - high from the first FETCH to the last SEND
//                done_o            - one-cycle pulse after the final byte
//                mem_addr_o[31:0]  - word-aligned byte address to the memory
//                mem_data_i[31:0]  - combinational read data for mem_addr_o
//                tx_data_o[7:0]    - byte to the transmitter
//                tx_valid_o        - tx_data_o holds a byte
//                tx_ready_i        - transmitter accepts the byte
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_dumper
  import mem_dumper_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam int                 c_IDX_W = idx_width(DEPTH);
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

  dump_state_t        r_state;
  logic [c_IDX_W-1:0] r_word_idx;
  logic               r_busy;
  logic               r_done;

  logic               w_load;
  logic               w_last;

  // The memory returns data in the same cycle, so FETCH loads directly.
  assign w_load = (r_state == FETCH);

  word_serializer u_serializer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_load),
    .word_i  (mem_data_i),
    .ready_i (tx_ready_i),
    .data_o  (tx_data_o),
    .valid_o (tx_valid_o),
    .last_o  (w_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_word_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_word_idx <= '0;
            r_busy     <= 1'b1;
            r_state    <= FETCH;
          end
        end
        FETCH: begin
          r_state <= SEND;
        end
        SEND: begin
          if (w_last) begin
            // Exact terminal compare: the counter never wraps past DEPTH-1.
            if (r_word_idx == c_LAST) begin
              r_word_idx <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_word_idx <= r_word_idx + c_IDX_W'(1);
              r_state    <= FETCH;
            end
          end
        end
        DONE: begin
          // start_i is deliberately not looked at here: no queued restart.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign mem_addr_o = 32'(r_word_idx) << ADDR_LSB;

endmodule
`default_nettype wire
